// File: rtl/dbg_pkg.sv
// dbg_pkg: opcodes, default ack byte and FSM state encoding for bus_dbg_master
package dbg_pkg;
  localparam logic [7:0] OPC_WRITE   = 8'h57;
  localparam logic [7:0] OPC_READ    = 8'h52;
  localparam logic [7:0] ACK_DEFAULT = 8'h06;
  typedef enum logic [3:0] {
    S_IDLE, S_AH, S_AL, S_LEN, S_WGET, S_WSTB, S_RADR, S_RCAP, S_TXW, S_ACK
  } state_t;
endpackage

// File: rtl/bus_dbg_master.sv
// bus_dbg_master: rx command bytes (op, addr_hi, addr_lo, len, data) drive bus_req/AB/DO/WE_n/DI accesses; read data and write acks return on tx
module bus_dbg_master
  import dbg_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter logic [7:0] ACK_BYTE = ACK_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [ADDR_W-1:0] AB,
  output logic [7:0]        DO,
  output logic              WE_n,
  input  logic [7:0]        DI,
  output logic              busy,
  output logic              err
);
  state_t state, nxt;
  logic wr;
  logic [ADDR_W-1:0] addr, ab_q;
  logic [7:0] cnt;
  logic rx_fire, access, last;
  always_comb begin
    rx_ready = !reset && (state inside {S_IDLE, S_AH, S_AL, S_LEN, S_WGET});
    rx_fire  = rx_valid && rx_ready;
    access   = bus_gnt && (state == S_WSTB || state == S_RADR);
    AB       = access ? addr : ab_q;
    WE_n     = !(bus_gnt && state == S_WSTB);
    busy     = state != S_IDLE;
    last     = cnt == 8'd0;
  end
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: nxt = rx_fire && (rx_data == OPC_WRITE || rx_data == OPC_READ) ? S_AH : S_IDLE;
      S_AH:   nxt = rx_fire ? S_AL : S_AH;
      S_AL:   nxt = rx_fire ? S_LEN : S_AL;
      S_LEN:  nxt = rx_fire ? (wr ? S_WGET : S_RADR) : S_LEN;
      S_WGET: nxt = rx_fire ? S_WSTB : S_WGET;
      S_WSTB: nxt = bus_gnt ? (last ? S_ACK : S_WGET) : S_WSTB;
      S_RADR: nxt = bus_gnt ? S_RCAP : S_RADR;
      S_RCAP: nxt = S_TXW;
      S_TXW:  nxt = tx_ready ? (last ? S_IDLE : S_RADR) : S_TXW;
      S_ACK:  nxt = tx_ready ? S_IDLE : S_ACK;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) state <= S_IDLE;
    else state <= nxt;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr       <= 1'b0;
      addr     <= '0;
      ab_q     <= '0;
      cnt      <= 8'd0;
      DO       <= 8'd0;
      bus_req  <= 1'b0;
      tx_data  <= 8'd0;
      tx_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= state == S_IDLE && rx_fire && rx_data != OPC_WRITE && rx_data != OPC_READ;
      case (state)
        S_IDLE: if (rx_fire) wr <= rx_data == OPC_WRITE;
        S_AH:   if (rx_fire) addr <= ADDR_W'({rx_data, 8'h00});
        S_AL:   if (rx_fire) addr <= addr | ADDR_W'(rx_data);
        S_LEN: if (rx_fire) begin
          cnt     <= rx_data;
          bus_req <= 1'b1;
        end
        S_WGET: if (rx_fire) DO <= rx_data;
        S_WSTB: if (bus_gnt) begin
          ab_q <= addr;
          addr <= addr + ADDR_W'(1);
          cnt  <= cnt - 8'd1;
          if (last) begin
            bus_req  <= 1'b0;
            tx_data  <= ACK_BYTE;
            tx_valid <= 1'b1;
          end
        end
        S_RADR: if (bus_gnt) ab_q <= addr;
        S_RCAP: begin
          tx_data  <= DI;
          tx_valid <= 1'b1;
          if (last) bus_req <= 1'b0;
        end
        S_TXW: if (tx_ready) begin
          tx_valid <= 1'b0;
          addr     <= addr + ADDR_W'(1);
          cnt      <= cnt - 8'd1;
        end
        S_ACK: if (tx_ready) tx_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/bus_dbg_master.md
Name: bus_dbg_master

Overview:
- Debug bus initiator for the 6502 SoC: the write/read end of the CPU memory bus, driven from a byte stream instead of the CPU.
- Accepts commands from a byte source (normally the ACIA RX path), requests the bus from the arbiter, and performs byte writes or reads on the same address/data/WE_n bus that RAM, ROM and peripherals decode.
- Read data is returned as a byte stream (to the TX path).
- Used for program loading and memory inspection while the CPU is held off via RDY.

Parameters:
- ADDR_W, 16, bus address width.
- ACK_BYTE, 8'h06, byte emitted after a completed write burst.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- rx_data, input, 8, command/data byte in.
- rx_valid, input, 1, rx_data valid.
- rx_ready, output, 1, byte accepted when rx_valid & rx_ready.
- tx_data, output, 8, response byte out.
- tx_valid, output, 1, tx_data valid.
- tx_ready, input, 1, sink accepts on tx_valid & tx_ready.
- bus_req, output, 1, request bus (arbiter drops CPU RDY).
- bus_gnt, input, 1, bus granted this cycle.
- AB, output, ADDR_W, bus address.
- DO, output, 8, write data.
- WE_n, output, 1, active-low write strobe.
- DI, input, 8, read data; valid one cycle after AB (synchronous memories, registered mux select).
- busy, output, 1, high in any state other than IDLE.
- err, output, 1, one-cycle pulse on unknown opcode.

Behaviour:
- Applies to both clock and reset: single clock domain, all state on posedge clk; reset is synchronous and active-high; port names are clk and reset.
- Reset values: AB=0, DO=0, WE_n=1, bus_req=0, tx_valid=0, tx_data=0, err=0, busy=0, state=IDLE. rx_ready=0 while reset is high.
- Command format: opcode, addr_hi, addr_lo, len. Burst count N = len+1 (1..256).
  - 'W' = 8'h57: N data bytes follow.
  - 'R' = 8'h52: no data bytes follow.
- FSM states: IDLE, AH, AL, LEN, WGET, WSTB, RADR, RCAP, TXW, ACK.
- IDLE: rx_ready=1.
  - 'W' or 'R' accepted -> AH (opcode latched).
  - Any other byte -> err=1 for 1 cycle, byte dropped, stay IDLE.
- AH, AL, LEN: rx_ready=1; each accepted byte latches its field.
  - After LEN: bus_req goes to 1 the next cycle; go to WGET for 'W', RADR for 'R'.
- WGET: rx_ready=1; accepted byte -> DO, go to WSTB.
- WSTB: rx_ready=0.
  - When bus_gnt=1: AB=addr and WE_n=0 for exactly that one cycle.
  - Then addr+1 and cnt-1; go to WGET if cnt>0, else ACK.
  - When bus_gnt=0: WE_n=1, wait.
- RADR: when bus_gnt=1, present AB=addr with WE_n=1 for one cycle, then go to RCAP.
- RCAP: capture DI into tx_data, tx_valid=1, go to TXW. The capture happens regardless of bus_gnt in this cycle.
- TXW: hold tx_data/tx_valid stable until tx_ready. On accept: addr+1, cnt-1; go to RADR if cnt>0, else IDLE. No bus access while waiting.
- ACK: tx_data=ACK_BYTE, tx_valid=1 until accepted, then IDLE.
- bus_req:
  - Rises after LEN.
  - Falls in the cycle the last bus access completes (the WSTB strobe cycle or the last RCAP).
  - Stays high through grant gaps and backpressure within a burst.
- Address arithmetic: ADDR_W-bit modulo; 16'hFFFF+1 = 16'h0000. cnt is an 8-bit down-counter.
- WE_n is 0 only in WSTB with bus_gnt=1, never for two consecutive cycles.
- AB holds its last value when the bus is idle.
- Reset mid-burst: burst aborts; next cycle all outputs are at reset values; no response byte is sent.
- Simultaneous rx_valid in a non-accepting state: ignored (rx_ready=0); the source holds the byte.

Decomposition:
- Package dbg_pkg: OPC_WRITE=8'h57, OPC_READ=8'h52, ACK default, state encoding localparams.
- No sub-module: a single FSM plus address/count registers; estimated 150-250 lines.
- SoC integration (outside this block): RDY/arbiter and an AB/DO/WE_n mux.

Test Plan:
- Write: 57 00 10 02 AA BB CC, gnt=1 -> three single-cycle WE_n=0 strobes at 0010/AA, 0011/BB, 0012/CC; then tx 06; bus_req low after the last strobe.
- Read: RAM model preloaded 0FFE=5A, 0FFF=A5; send 52 0F FE 01 -> AB 0FFE then 0FFF; tx bytes 5A, A5; each capture taken one cycle after its address phase.
- Wrap: 57 FF FF 01 11 22 -> writes FFFF=11 then 0000=22; ACK 06.
- Grant gap: gnt low for 5 cycles mid 4-byte read -> no new address phases during the gap; bus_req stays 1; tx sequence matches memory exactly.
- Backpressure: tx_ready=0 for 10 cycles on byte 2 -> tx_data stable, no bus access, resumes correctly.
- Error/reset: byte 41 in IDLE -> err pulse of exactly 1 cycle, then 52 00 00 00 works. Reset asserted during WSTB -> next cycle WE_n=1, bus_req=0, tx_valid=0, busy=0.
